// File: rtl/iob_gpio_maxtrack.sv
// Memory-mapped GPIO block with a lane-wise max/min tracker over written samples.
// One lane is compared per cycle; RESULT/COUNT/IRQ_PEND update in a single UPDATE cycle.
module iob_gpio_maxtrack #(
  parameter int unsigned GPIO_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned LANE_W  = 8,
  parameter int unsigned N_LANES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  input  logic [GPIO_W-1:0]   gpio_input,
  input  logic [11:0]         gpio_sw,
  output logic [GPIO_W-1:0]   gpio_output,
  output logic [GPIO_W-1:0]   gpio_output_enable,
  output logic                irq
);

  localparam int unsigned SAMP_W = LANE_W * N_LANES;
  localparam int unsigned LIDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int unsigned CNT_W  = 16;

  localparam logic [ADDR_W-1:0] A_DATA   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_THRESH = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_RESULT = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_COUNT  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_INPUT  = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_OUTPUT = ADDR_W'(7);
  localparam logic [ADDR_W-1:0] A_OE     = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] A_SWITCH = ADDR_W'(9);

  typedef enum logic [1:0] {IDLE, SCAN, UPDATE} state_t;

  state_t              state_q;
  logic [SAMP_W-1:0]   sample_q;
  logic                mode_lat_q;
  logic [LANE_W-1:0]   cand_q;
  logic [LIDX_W-1:0]   lane_q;
  logic                mode_q;
  logic                irq_en_q;
  logic [LANE_W-1:0]   thresh_q;
  logic [LANE_W-1:0]   result_q;
  logic [CNT_W-1:0]    count_q;
  logic                pend_q;
  logic                ovf_q;
  logic [GPIO_W-1:0]   out_q;
  logic [GPIO_W-1:0]   oe_q;
  logic [GPIO_W-1:0]   sync1_q;
  logic [GPIO_W-1:0]   sync2_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ready_q;
  logic                irq_q;

  logic                wr_c, rd_c, busy_c;
  logic                ctrl_wr_c, data_wr_c, stat_wr_c, clear_c;
  logic [LANE_W-1:0]   lane_val_c;
  logic                better_c, replace_c, hit_c, pend_set_c;
  logic                pend_d, ovf_d, irq_en_d, irq_d;
  logic [DATA_W-1:0]   rdata_c;

  assign wr_c      = valid && (|wstrb);
  assign rd_c      = valid && !(|wstrb);
  assign busy_c    = (state_q != IDLE);
  assign ctrl_wr_c = wr_c && (address == A_CTRL);
  assign data_wr_c = wr_c && (address == A_DATA);
  assign stat_wr_c = wr_c && (address == A_STATUS);
  // Explicit CLEAR or a MODE flip both restart tracking from the new mode's identity value
  assign clear_c   = ctrl_wr_c && (wdata[1] || (wdata[0] != mode_q));

  assign lane_val_c = LANE_W'(sample_q >> (LANE_W * lane_q));
  assign better_c   = mode_lat_q ? (lane_val_c < cand_q) : (lane_val_c > cand_q);
  assign replace_c  = mode_lat_q ? (cand_q < result_q) : (cand_q > result_q);
  assign hit_c      = mode_lat_q ? (cand_q <= thresh_q) : (cand_q >= thresh_q);
  assign pend_set_c = (state_q == UPDATE) && hit_c && !clear_c;

  // Sticky status: a same-cycle set beats a W1C clear
  assign pend_d   = pend_set_c || (pend_q && !(stat_wr_c && wdata[1]));
  assign ovf_d    = (data_wr_c && busy_c) || (ovf_q && !(stat_wr_c && wdata[2]));
  assign irq_en_d = ctrl_wr_c ? wdata[2] : irq_en_q;
  assign irq_d    = pend_d && irq_en_d;

  always_comb begin
    rdata_c = '0;
    case (address)
      A_CTRL:   rdata_c = DATA_W'({irq_en_q, 1'b0, mode_q});
      A_THRESH: rdata_c = DATA_W'(thresh_q);
      A_RESULT: rdata_c = DATA_W'(result_q);
      A_COUNT:  rdata_c = DATA_W'(count_q);
      A_STATUS: rdata_c = DATA_W'({ovf_q, pend_q, busy_c});
      A_INPUT:  rdata_c = DATA_W'(sync2_q);
      A_OUTPUT: rdata_c = DATA_W'(out_q);
      A_OE:     rdata_c = DATA_W'(oe_q);
      A_SWITCH: rdata_c = DATA_W'(gpio_sw);
      default:  rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      sample_q   <= '0;
      mode_lat_q <= 1'b0;
      cand_q     <= '0;
      lane_q     <= '0;
      mode_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      thresh_q   <= '0;
      result_q   <= '0;
      count_q    <= '0;
      pend_q     <= 1'b0;
      ovf_q      <= 1'b0;
      out_q      <= '0;
      oe_q       <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ready_q  <= valid;
      rdata_q  <= rd_c ? rdata_c : '0;
      sync1_q  <= gpio_input;
      sync2_q  <= sync1_q;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;

      if (wr_c) begin
        case (address)
          A_CTRL:   mode_q   <= wdata[0];
          A_THRESH: thresh_q <= LANE_W'(wdata);
          A_OUTPUT: out_q    <= GPIO_W'(wdata);
          A_OE:     oe_q     <= GPIO_W'(wdata);
          default:  ;
        endcase
      end

      if (clear_c) begin
        state_q  <= IDLE;
        lane_q   <= '0;
        count_q  <= '0;
        result_q <= wdata[0] ? '1 : '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (data_wr_c) begin
              sample_q   <= SAMP_W'(wdata);
              mode_lat_q <= mode_q;
              cand_q     <= LANE_W'(wdata);
              lane_q     <= '0;
              state_q    <= SCAN;
            end
          end
          SCAN: begin
            if (better_c) cand_q <= lane_val_c;
            if (lane_q == LIDX_W'(N_LANES - 1)) state_q <= UPDATE;
            else lane_q <= lane_q + LIDX_W'(1);
          end
          UPDATE: begin
            if (replace_c) result_q <= cand_q;
            if (count_q != {CNT_W{1'b1}}) count_q <= count_q + CNT_W'(1);
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rdata              = rdata_q;
  assign ready              = ready_q;
  assign irq                = irq_q;
  assign gpio_output        = out_q;
  assign gpio_output_enable = oe_q;

endmodule

// File: tb/tb_iob_gpio_maxtrack.sv
// Directed bench for iob_gpio_maxtrack: register map, tracker timing, status, irq and reset.
module tb_iob_gpio_maxtrack;

  localparam logic [3:0] A_DATA   = 4'd0;
  localparam logic [3:0] A_CTRL   = 4'd1;
  localparam logic [3:0] A_THRESH = 4'd2;
  localparam logic [3:0] A_RESULT = 4'd3;
  localparam logic [3:0] A_COUNT  = 4'd4;
  localparam logic [3:0] A_STATUS = 4'd5;
  localparam logic [3:0] A_INPUT  = 4'd6;
  localparam logic [3:0] A_OUTPUT = 4'd7;
  localparam logic [3:0] A_OE     = 4'd8;
  localparam logic [3:0] A_SWITCH = 4'd9;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [3:0]  address;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] gpio_input;
  logic [11:0] gpio_sw;
  logic [31:0] gpio_output;
  logic [31:0] gpio_output_enable;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  iob_gpio_maxtrack dut (
    .clk                (clk),
    .rst                (rst),
    .valid              (valid),
    .address            (address),
    .wdata              (wdata),
    .wstrb              (wstrb),
    .rdata              (rdata),
    .ready              (ready),
    .gpio_input         (gpio_input),
    .gpio_sw            (gpio_sw),
    .gpio_output        (gpio_output),
    .gpio_output_enable (gpio_output_enable),
    .irq                (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Bus tasks start and end on a falling edge
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    valid = 1'b1; address = a; wdata = d; wstrb = 4'hF;
    @(negedge clk);
    valid = 1'b0; wstrb = 4'h0; wdata = '0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    valid = 1'b1; address = a; wstrb = 4'h0;
    @(negedge clk);
    valid = 1'b0;
    d = rdata;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check_eq(tag, d, exp);
  endtask

  task automatic run_sample(input logic [31:0] d);
    bus_write(A_DATA, d);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; valid = 1'b0; address = '0; wdata = '0; wstrb = '0;
    gpio_input = '0; gpio_sw = 12'hABC;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    check_eq("rst_gpio_out", gpio_output, 32'h0);
    check_eq("rst_gpio_oe", gpio_output_enable, 32'h0);
    check_eq("rst_irq", {31'b0, irq}, 32'h0);
    check_eq("rst_ready", {31'b0, ready}, 32'h0);
    check_eq("rst_rdata", rdata, 32'h0);
    rd_chk("rst_result", A_RESULT, 32'h0);
    rd_chk("rst_status", A_STATUS, 32'h0);

    // Max tracking with exact latency: STATUS read in the UPDATE cycle still sees BUSY
    bus_write(A_DATA, 32'h11807F22);
    repeat (4) @(negedge clk);
    rd_chk("max_busy_in_update", A_STATUS, 32'h1);
    rd_chk("max_result", A_RESULT, 32'h80);
    rd_chk("max_count", A_COUNT, 32'h1);
    rd_chk("max_status", A_STATUS, 32'h2);
    check_eq("max_irq_disabled", {31'b0, irq}, 32'h0);
    run_sample(32'h05060708);
    rd_chk("max2_result", A_RESULT, 32'h80);
    rd_chk("max2_count", A_COUNT, 32'h2);

    // Mode flip to min clears the tracker
    bus_write(A_CTRL, 32'h1);
    rd_chk("min_clr_result", A_RESULT, 32'hFF);
    rd_chk("min_clr_count", A_COUNT, 32'h0);
    rd_chk("min_ctrl", A_CTRL, 32'h1);
    run_sample(32'h30102040);
    rd_chk("min_result", A_RESULT, 32'h10);
    rd_chk("min_count", A_COUNT, 32'h1);
    rd_chk("min_status_pend_kept", A_STATUS, 32'h2);
    bus_write(A_STATUS, 32'h6);
    rd_chk("w1c_all", A_STATUS, 32'h0);

    // Overflow: second DATA write two cycles later is dropped
    bus_write(A_CTRL, 32'h0);
    rd_chk("max_clr_result", A_RESULT, 32'h0);
    bus_write(A_DATA, 32'h000000AA);
    @(negedge clk);
    bus_write(A_DATA, 32'h000000FF);
    repeat (5) @(negedge clk);
    rd_chk("ovf_result", A_RESULT, 32'hAA);
    rd_chk("ovf_count", A_COUNT, 32'h1);
    rd_chk("ovf_status", A_STATUS, 32'h6);
    bus_write(A_STATUS, 32'h4);
    rd_chk("ovf_w1c", A_STATUS, 32'h2);
    bus_write(A_STATUS, 32'h2);
    rd_chk("pend_w1c", A_STATUS, 32'h0);

    // W1C of IRQ_PEND in the same cycle the UPDATE sets it: set wins
    bus_write(A_DATA, 32'h00000001);
    repeat (4) @(negedge clk);
    bus_write(A_STATUS, 32'h2);
    rd_chk("set_wins", A_STATUS, 32'h2);
    rd_chk("set_wins_count", A_COUNT, 32'h2);
    bus_write(A_STATUS, 32'h2);

    // Threshold interrupt
    bus_write(A_THRESH, 32'h90);
    bus_write(A_CTRL, 32'h4);
    rd_chk("thresh_rb", A_THRESH, 32'h90);
    rd_chk("ctrl_rb", A_CTRL, 32'h4);
    rd_chk("ctrl_no_clear", A_RESULT, 32'hAA);
    check_eq("irq_before", {31'b0, irq}, 32'h0);
    run_sample(32'h00950000);
    check_eq("irq_set", {31'b0, irq}, 32'h1);
    rd_chk("irq_result", A_RESULT, 32'hAA);
    rd_chk("irq_count", A_COUNT, 32'h3);
    bus_write(A_STATUS, 32'h2);
    check_eq("irq_cleared", {31'b0, irq}, 32'h0);
    run_sample(32'h00000080);
    check_eq("irq_below_thresh", {31'b0, irq}, 32'h0);
    rd_chk("below_status", A_STATUS, 32'h0);
    rd_chk("below_count", A_COUNT, 32'h4);

    // Abort mid-SCAN via CLEAR
    bus_write(A_DATA, 32'h12345678);
    @(negedge clk);
    bus_write(A_CTRL, 32'h2);
    rd_chk("abort_status", A_STATUS, 32'h0);
    repeat (8) @(negedge clk);
    rd_chk("abort_count", A_COUNT, 32'h0);
    rd_chk("abort_result", A_RESULT, 32'h0);
    rd_chk("abort_ctrl", A_CTRL, 32'h0);

    // GPIO, switch, unmapped and read-only accesses
    rd_chk("switch", A_SWITCH, 32'h00000ABC);
    bus_write(A_OUTPUT, 32'hA5A50F0F);
    check_eq("wr_resp_ready", {31'b0, ready}, 32'h1);
    check_eq("wr_resp_rdata", rdata, 32'h0);
    @(negedge clk);
    check_eq("ready_pulse", {31'b0, ready}, 32'h0);
    check_eq("gpio_out", gpio_output, 32'hA5A50F0F);
    bus_write(A_OE, 32'h0000FFFF);
    check_eq("gpio_oe", gpio_output_enable, 32'h0000FFFF);
    rd_chk("out_rb", A_OUTPUT, 32'hA5A50F0F);
    rd_chk("oe_rb", A_OE, 32'h0000FFFF);
    gpio_input = 32'hDEADBEEF;
    rd_chk("input_sync_lag", A_INPUT, 32'h0);
    repeat (2) @(negedge clk);
    rd_chk("input_synced", A_INPUT, 32'hDEADBEEF);
    bus_write(4'hD, 32'hFFFFFFFF);
    rd_chk("unmapped_rd", 4'hD, 32'h0);
    bus_write(A_RESULT, 32'h55);
    rd_chk("ro_result", A_RESULT, 32'h0);

    // Reset mid-SCAN with everything non-zero
    bus_write(A_CTRL, 32'h4);
    run_sample(32'h000000FF);
    check_eq("pre_rst_irq", {31'b0, irq}, 32'h1);
    bus_write(A_OUTPUT, 32'hFFFFFFFF);
    bus_write(A_OE, 32'hFFFFFFFF);
    bus_write(A_DATA, 32'h00000077);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_eq("mid_rst_gpio_out", gpio_output, 32'h0);
    check_eq("mid_rst_gpio_oe", gpio_output_enable, 32'h0);
    check_eq("mid_rst_irq", {31'b0, irq}, 32'h0);
    check_eq("mid_rst_ready", {31'b0, ready}, 32'h0);
    repeat (8) @(negedge clk);
    rd_chk("mid_rst_result", A_RESULT, 32'h0);
    rd_chk("mid_rst_count", A_COUNT, 32'h0);
    rd_chk("mid_rst_status", A_STATUS, 32'h0);
    rd_chk("mid_rst_ctrl", A_CTRL, 32'h0);
    rd_chk("mid_rst_thresh", A_THRESH, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iob_gpio_maxtrack.md
IOB_GPIO_MAXTRACK -- requirements
Module: iob_gpio_maxtrack

Interface
REQ-001 SHALL have parameter GPIO_W, default 32, number of GPIO lines (GPIO_W <= DATA_W).
REQ-002 SHALL have parameter DATA_W, default 32, CPU data width.
REQ-003 SHALL have parameter ADDR_W, default 4, CPU word-address width.
REQ-004 SHALL have parameter LANE_W, default 8, sample lane width; legal range 2..16.
REQ-005 SHALL have parameter N_LANES, default 4, lanes per sample; power of two with LANE_W*N_LANES <= DATA_W.
REQ-006 SHALL have the following ports:
- clk  in  1  sole clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- valid  in  1  CPU request strobe.
- address  in  ADDR_W  word address.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte strobes; nonzero = write, zero = read.
- rdata  out  DATA_W  read data, valid while ready=1.
- ready  out  1  one-cycle response pulse.
- gpio_input  in  GPIO_W  external inputs.
- gpio_sw  in  12  switch inputs.
- gpio_output  out  GPIO_W  output values.
- gpio_output_enable  out  GPIO_W  per-line tristate enable.
- irq  out  1  threshold interrupt.

Function
REQ-007 SHALL respond to every valid with ready=1 exactly one cycle later; rdata registered, 0 on write responses.
REQ-008 SHALL decode these word addresses; unmapped reads return 0, unmapped writes are ignored:
- 0 DATA (W): sample.
- 1 CTRL (RW): bit0 MODE (0 max, 1 min), bit1 CLEAR (self-clearing), bit2 IRQ_EN.
- 2 THRESH (RW, LANE_W).
- 3 RESULT (R, LANE_W).
- 4 COUNT (R, 16).
- 5 STATUS (R, W1C): bit0 BUSY, bit1 IRQ_PEND, bit2 OVERFLOW.
- 6 INPUT (R).
- 7 OUTPUT (RW).
- 8 OUTPUT_EN (RW).
- 9 SWITCH (R, 12).
REQ-009 SHALL register gpio_input through two flops; INPUT reads the second stage.
REQ-010 SHALL drive gpio_output and gpio_output_enable from the low GPIO_W bits of OUTPUT and OUTPUT_EN.
REQ-011 SHALL use FSM states IDLE, SCAN, UPDATE: IDLE->SCAN on DATA write; SCAN holds N_LANES cycles; SCAN->UPDATE; UPDATE->IDLE.
REQ-012 SHALL, on entering SCAN, latch the sample and MODE and initialise the candidate to lane 0.
REQ-013 SHALL, during SCAN, compare one lane per cycle (lane 0 up to lane N_LANES-1), unsigned, against the candidate.
- Max mode: candidate = larger.
- Min mode: candidate = smaller.
REQ-014 SHALL, in UPDATE, replace RESULT only if the candidate is strictly greater (max) or strictly less (min); ties leave RESULT unchanged.
REQ-015 SHALL, in UPDATE, increment COUNT, saturating at 0xFFFF.
REQ-016 SHALL, in UPDATE, set IRQ_PEND if candidate >= THRESH (max) or <= THRESH (min).
REQ-017 SHALL make RESULT and COUNT visible N_LANES+2 cycles after the DATA-write valid cycle.
REQ-018 SHALL assert BUSY in SCAN and UPDATE.
REQ-019 SHALL, on a DATA write while BUSY, drop the sample, set OVERFLOW and leave the scan in progress unaffected.
REQ-020 SHALL clear the tracker on CLEAR=1 or on a CTRL write that changes MODE.
- Clear takes effect the cycle after the write.
- FSM returns to IDLE and aborts any scan.
- COUNT=0.
- RESULT = 0 if the new MODE is max, or all-ones (LANE_W bits) if min.
- IRQ_PEND and OVERFLOW are not affected.
REQ-021 SHALL, on a STATUS write, clear each of bits 1 and 2 written as 1; when a set and a clear hit the same bit in the same cycle, set wins.
REQ-022 SHALL drive irq = IRQ_PEND & IRQ_EN, registered.

Reset
REQ-023 SHALL, on rst=0 at a clock edge, reset the block:
- FSM to IDLE.
- ready=0, rdata=0.
- CTRL, THRESH, RESULT, COUNT, STATUS bits = 0.
- OUTPUT=0, OUTPUT_EN=0, irq=0.
- Synchroniser flops = 0.
REQ-024 SHALL apply reset regardless of FSM state and discard any scan in progress.

Verification
REQ-025 SHALL cover max tracking: write DATA 0x11807F22 -> after 6 cycles RESULT=0x80, COUNT=1, BUSY=0; then write 0x05060708 -> RESULT=0x80, COUNT=2.
REQ-026 SHALL cover min mode: write CTRL=0x1 -> RESULT=0xFF, COUNT=0; then write DATA 0x30102040 -> RESULT=0x10.
REQ-027 SHALL cover overflow: write DATA 0x000000AA, then write 0x000000FF two cycles later -> RESULT=0xAA, COUNT=1, OVERFLOW=1; write STATUS=0x4 -> OVERFLOW=0.
REQ-028 SHALL cover the interrupt: set THRESH=0x90 and CTRL=0x4, write DATA 0x00950000 -> irq=1 after UPDATE; write STATUS=0x2 -> irq=0.
REQ-029 SHALL cover abort: write CTRL=0x2 during SCAN -> FSM IDLE, COUNT=0, RESULT=0, COUNT never increments for the aborted sample.
REQ-030 SHALL cover reset: drive rst=0 for one cycle mid-SCAN with OUTPUT=0xFFFFFFFF -> all outputs, RESULT and COUNT read 0.
